// File: rtl/fetch_unit.sv
// RV32I fetch sequencer: PC generation, ROM read issue, redirect and fault handling.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC      = 32'h0100_0000,
  parameter int unsigned ROM_WORDS     = 512,
  parameter logic [31:0] ROM_BASE_MASK = 32'h0100_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        read_instr,
  output logic [31:0] addr_out,
  input  logic [31:0] instr_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault_valid,
  output logic [1:0]  fault_code,
  output logic [31:0] fault_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_redirect_cnt
`endif
);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;
  localparam logic [31:0] ROM_WORDS_W = 32'(ROM_WORDS);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        fault_valid_q, fault_valid_d;
  logic [1:0]  fault_code_q, fault_code_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic        redir, legal, adv, issue, take_fault;

  function automatic logic is_legal(input logic [31:0] a);
    logic [31:0] idx;
    idx = (a & ~ROM_BASE_MASK) >> 2;
    return (a[1:0] == 2'b00) && (idx < ROM_WORDS_W);
  endfunction

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    out_valid_d   = out_valid_q;
    out_pc_d      = out_pc_q;
    fault_valid_d = fault_valid_q;
    fault_code_d  = fault_code_q;
    fault_pc_d    = fault_pc_q;
    adv           = 1'b0;
    issue         = 1'b0;
    take_fault    = 1'b0;
    // Redirects are not recognised until the BOOT cycle has passed.
    redir         = redirect_valid && (state_q != ST_BOOT);
    addr_out      = redir ? redirect_pc : pc_q;
    legal         = is_legal(addr_out);

    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        adv = !out_valid_q || out_ready || redirect_valid;
        if (adv) begin
          issue      = legal;
          take_fault = !legal;
        end
      end
      ST_FAULT: begin
        if (redirect_valid) begin
          issue      = legal;
          take_fault = !legal;
        end
      end
      default: state_d = ST_BOOT;
    endcase

    if (issue) begin
      pc_d          = addr_out + 32'd4;
      out_pc_d      = addr_out;
      out_valid_d   = 1'b1;
      fault_valid_d = 1'b0;
      fault_code_d  = 2'b00;
      state_d       = ST_RUN;
    end
    if (take_fault) begin
      out_valid_d   = 1'b0;
      fault_valid_d = 1'b1;
      fault_code_d  = (addr_out[1:0] != 2'b00) ? 2'b01 : 2'b10;
      fault_pc_d    = addr_out;
      state_d       = ST_FAULT;
    end
    read_instr = issue;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      out_valid_q   <= 1'b0;
      out_pc_q      <= 32'd0;
      fault_valid_q <= 1'b0;
      fault_code_q  <= 2'b00;
      fault_pc_q    <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      out_valid_q   <= out_valid_d;
      out_pc_q      <= out_pc_d;
      fault_valid_q <= fault_valid_d;
      fault_code_q  <= fault_code_d;
      fault_pc_q    <= fault_pc_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_pc_q;
  assign out_instr   = instr_in;
  assign fault_valid = fault_valid_q;
  assign fault_code  = fault_code_q;
  assign fault_pc    = fault_pc_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_redir_q, perf_redir_d;

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    perf_fetch_d = perf_fetch_q;
    perf_stall_d = perf_stall_q;
    perf_redir_d = perf_redir_q;
    if (issue && (perf_fetch_q != 32'hFFFF_FFFF))
      perf_fetch_d = perf_fetch_q + 32'd1;
    if (out_valid_q && !out_ready && (perf_stall_q != 32'hFFFF_FFFF))
      perf_stall_d = perf_stall_q + 32'd1;
    if (redir && (perf_redir_q != 32'hFFFF_FFFF))
      perf_redir_d = perf_redir_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_q <= 32'd0;
      perf_stall_q <= 32'd0;
      perf_redir_q <= 32'd0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
      perf_redir_q <= perf_redir_d;
    end
  end

  assign perf_fetch_cnt    = perf_fetch_q;
  assign perf_stall_cnt    = perf_stall_q;
  assign perf_redirect_cnt = perf_redir_q;
`endif

endmodule
